byte_inv_permutation_unit: RTL and testbench
============================================

# byte_inv_permutation_unit

Byte-serial InvShiftRows stage for the AES decryption datapath. It accepts a 16-byte AES state one byte per cycle in column-major order (byte k = 4·column + row). It emits the same block, one byte per cycle, with each row r rotated right by r positions. Two 16-byte banks in ping-pong arrangement let the stage sustain one byte per cycle between the inverse S-box stage and AddRoundKey. A parameter selects forward ShiftRows instead, so the same block serves encryption-side checking.

## Interface
- INVERSE, 1: 1 = InvShiftRows, 0 = forward ShiftRows
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-low
- rst_synch  input  1  synchronous clear, active-high; aborts any partial or buffered block
- in_valid  input  1  in_byte carries a valid byte
- in_ready  output  1  unit can accept a byte this cycle
- in_byte  input  8  state byte, column-major order, byte 0 first
- out_valid  output  1  out_byte valid
- out_ready  input  1  consumer accepts out_byte this cycle
- out_byte  output  8  permuted state byte, column-major order
- out_last  output  1  high with the 16th output byte of a block

## Operation
- Storage: bank[0..1][0..15] of 8-bit registers; full[0..1] flags; wr_bank, wr_cnt (4 bit); rd_bank, rd_cnt (4 bit).
- Write:
  - in_ready = !full[wr_bank].
  - When in_valid && in_ready, bank[wr_bank][wr_cnt] <= in_byte and wr_cnt increments.
  - When wr_cnt == 15 on an accept, set full[wr_bank], toggle wr_bank, and wrap wr_cnt to 0.
- Read:
  - out_valid = full[rd_bank].
  - out_byte = bank[rd_bank][src(rd_cnt)].
  - out_last = out_valid && rd_cnt == 15.
  - When out_valid && out_ready, rd_cnt increments. When rd_cnt == 15, clear full[rd_bank], toggle rd_bank, and wrap rd_cnt to 0.
- Source map, for k = 4c + r:
  - INVERSE=1: src(k) = 4·((c − r) mod 4) + r. Sequence: 0,13,10,7,4,1,14,11,8,5,2,15,12,9,6,3.
  - INVERSE=0: src(k) = 4·((c + r) mod 4) + r. Sequence: 0,5,10,15,4,9,14,3,8,13,2,7,12,1,6,11.
  - All mod-4 arithmetic is done on 2-bit fields with natural wrap.
- Simultaneous events:
  - A write completion and a read completion in the same cycle always touch different banks. Both updates take effect.
  - When both banks are full, in_ready = 0. Input stalls until the read side frees a bank; no byte is lost or overwritten.
- Output bytes are stable while out_valid && !out_ready.
- rst (async, low): all banks, flags, pointers and counters go to 0.
- rst_synch (sync, high): same clear, applied on the clock edge. It takes priority over any write or read in that cycle, and that cycle's handshakes are discarded.
- Reset values: in_ready=1, out_valid=0, out_last=0, out_byte=8'h00.

## Timing
- Latency: the 16th input byte is accepted at edge t. out_valid rises in cycle t+1, presenting output byte 0.
- Throughput: one byte per cycle sustained, with no bubble between blocks when out_ready is held high.
- Combinational paths:
  - out_byte and out_valid are combinational from registers only (16:1 mux on rd_cnt and rd_bank); no input-to-output combinational path.
  - in_ready depends on registers only and not on out_ready. The read-side bank release becomes visible to in_ready one cycle later.
- A reset assertion mid-block drops the partial block silently; the next byte accepted is byte 0 of a new block.

## Structure
- aes_pkg holds:
  - localparam AES_BLOCK_BYTES = 16;
  - typedef logic [7:0] aes_byte_t;
  - function shift_rows_src(k, inverse), returning the 4-bit source index. The forward unit shares this function.
- Sub-module byte_inv_permutation_controller owns all flags, pointers and counters and the handshake outputs. It drives write-enable, write address, read address and bank selects.
- The top level holds the bank registers and the output mux.

## Test plan
- Single block with INVERSE=1: in_byte = 0x00..0x0F, out_ready=1 → out_byte = 00,0D,0A,07,04,01,0E,0B,08,05,02,0F,0C,09,06,03; out_valid first high one cycle after byte 0x0F is accepted; out_last on 0x03.
- Round trip: an INVERSE=0 instance feeding an INVERSE=1 instance with random blocks → output equals input, byte for byte.
- Back-to-back: three blocks streamed with out_ready=1 → 48 consecutive out_valid cycles with no gap; out_last on cycles 16, 32 and 48 of the output stream.
- Backpressure: out_ready=0 while 32 bytes are offered → in_ready falls after 32 accepts; out_byte holds 0x00. Then release out_ready → both blocks drain in order.
- rst_synch after 7 input bytes, then 16 fresh bytes 0x10..0x1F → output is the permutation of 0x10..0x1F only.
- Async rst pulsed mid-drain (rd_cnt=5) → out_valid=0, in_ready=1 and out_byte=0x00 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES datapath types and the ShiftRows source-index helper
package aes_pkg;

    localparam int AES_BLOCK_BYTES = 16;

    typedef logic [7:0] aes_byte_t;

    // k = 4*column + row; the column field wraps naturally in 2 bits.
    function automatic logic [3:0] shift_rows_src(input logic [3:0] k, input logic inverse);
        logic [1:0] col;
        logic [1:0] row;
        logic [1:0] src_col;
        col     = k[3:2];
        row     = k[1:0];
        src_col = inverse ? (col - row) : (col + row);
        return {src_col, row};
    endfunction

endpackage

// File: rtl/byte_inv_permutation_controller.sv
// rtl/byte_inv_permutation_controller.sv - ping-pong bank flags, pointers and stream handshakes
module byte_inv_permutation_controller
    import aes_pkg::*;
#(
    parameter bit INVERSE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rst_synch,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       out_ready,
    output logic       out_valid,
    output logic       out_last,
    output logic       wr_en,
    output logic       wr_bank,
    output logic [3:0] wr_addr,
    output logic       rd_bank,
    output logic [3:0] rd_addr
);

    logic [1:0] full;
    logic [1:0] full_nxt;
    logic [3:0] wr_cnt;
    logic [3:0] rd_cnt;
    logic       rd_fire;
    logic       wr_done;
    logic       rd_done;

    assign in_ready  = !full[wr_bank];
    assign out_valid = full[rd_bank];
    assign out_last  = out_valid && (rd_cnt == 4'd15);

    assign wr_en   = in_valid && in_ready;
    assign rd_fire = out_valid && out_ready;
    assign wr_done = wr_en && (wr_cnt == 4'd15);
    assign rd_done = rd_fire && (rd_cnt == 4'd15);

    assign wr_addr = wr_cnt;
    assign rd_addr = shift_rows_src(rd_cnt, INVERSE);

    // Completions in the same cycle always hit different banks, so both apply.
    always_comb begin
        full_nxt = full;
        if (wr_done) full_nxt[wr_bank] = 1'b1;
        if (rd_done) full_nxt[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            wr_cnt  <= 4'd0;
            rd_bank <= 1'b0;
            rd_cnt  <= 4'd0;
        end else if (rst_synch) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            wr_cnt  <= 4'd0;
            rd_bank <= 1'b0;
            rd_cnt  <= 4'd0;
        end else begin
            full <= full_nxt;
            if (wr_en) begin
                wr_cnt <= wr_cnt + 4'd1;
                if (wr_done) wr_bank <= ~wr_bank;
            end
            if (rd_fire) begin
                rd_cnt <= rd_cnt + 4'd1;
                if (rd_done) rd_bank <= ~rd_bank;
            end
        end
    end

endmodule

// File: rtl/byte_inv_permutation_unit.sv
// rtl/byte_inv_permutation_unit.sv - byte-serial (Inv)ShiftRows with two ping-pong state banks
module byte_inv_permutation_unit
    import aes_pkg::*;
#(
    parameter bit INVERSE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rst_synch,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_byte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_byte,
    output logic       out_last
);

    aes_byte_t  bank [2][AES_BLOCK_BYTES];
    logic       wr_en;
    logic       wr_bank;
    logic [3:0] wr_addr;
    logic       rd_bank;
    logic [3:0] rd_addr;

    byte_inv_permutation_controller #(
        .INVERSE (INVERSE)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .rst_synch (rst_synch),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .wr_en     (wr_en),
        .wr_bank   (wr_bank),
        .wr_addr   (wr_addr),
        .rd_bank   (rd_bank),
        .rd_addr   (rd_addr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < AES_BLOCK_BYTES; i++)
                    bank[b][i] <= '0;
        end else if (rst_synch) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < AES_BLOCK_BYTES; i++)
                    bank[b][i] <= '0;
        end else if (wr_en) begin
            bank[wr_bank][wr_addr] <= in_byte;
        end
    end

    // Cleared banks make out_byte read 8'h00 straight out of reset.
    assign out_byte = bank[rd_bank][rd_addr];

endmodule

// File: tb/tb_byte_inv_permutation_unit.sv
// tb/tb_byte_inv_permutation_unit.sv - randomized and directed bench for byte_inv_permutation_unit
module tb_byte_inv_permutation_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rst_synch = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_byte = 8'h00;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_byte;
    logic       out_last;

    logic       rt_synch = 1'b0;
    logic       rt_valid = 1'b0;
    logic [7:0] rt_byte = 8'h00;
    logic       rt_ready = 1'b1;
    logic       fwd_in_ready;
    logic       mid_valid;
    logic       mid_ready;
    logic [7:0] mid_byte;
    logic       mid_last;
    logic       rt_out_valid;
    logic [7:0] rt_out_byte;
    logic       rt_out_last;

    always #5 clk = ~clk;

    byte_inv_permutation_unit #(.INVERSE(1'b1)) dut (
        .clk(clk), .rst(rst), .rst_synch(rst_synch),
        .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
        .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte), .out_last(out_last)
    );

    byte_inv_permutation_unit #(.INVERSE(1'b0)) u_fwd (
        .clk(clk), .rst(rst), .rst_synch(rt_synch),
        .in_valid(rt_valid), .in_ready(fwd_in_ready), .in_byte(rt_byte),
        .out_valid(mid_valid), .out_ready(mid_ready), .out_byte(mid_byte), .out_last(mid_last)
    );

    byte_inv_permutation_unit #(.INVERSE(1'b1)) u_inv (
        .clk(clk), .rst(rst), .rst_synch(rt_synch),
        .in_valid(mid_valid), .in_ready(mid_ready), .in_byte(mid_byte),
        .out_valid(rt_out_valid), .out_ready(rt_ready), .out_byte(rt_out_byte), .out_last(rt_out_last)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rt_cmp = 0;
    always @(posedge clk) cyc++;

    logic [7:0] part[$];
    logic [7:0] exp_q[$];
    int         rd_idx = 0;
    bit         rst_seen = 1'b0;
    logic [7:0] log_b[$];
    bit         log_l[$];
    int         log_c[$];
    logic [7:0] rt_q[$];

    int inv_seq[16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};
    int fwd_seq[16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};

    function automatic int src_idx(int k, bit inv);
        int c = k / 4;
        int r = k % 4;
        int sc = inv ? ((c - r + 4) % 4) : ((c + r) % 4);
        return 4 * sc + r;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge rst) rst_seen = 1'b1;

    // Model: whole blocks queued once complete; output side pops bytes.
    always @(negedge clk) begin
        int  nb;
        bit  ev;
        bit  erdy;
        if (rst_seen || !rst) begin
            part.delete(); exp_q.delete(); rt_q.delete();
            rd_idx = 0;
            rst_seen = 1'b0;
        end
        nb   = (exp_q.size() + 15) / 16;
        erdy = (nb < 2);
        ev   = (exp_q.size() > 0);
        if (rst) begin
            chk("in_ready", in_ready, erdy);
            chk("out_valid", out_valid, ev);
            if (ev) begin
                chk("out_byte", out_byte, exp_q[0]);
                chk("out_last", out_last, rd_idx == 15);
            end
            if (rst_synch) begin
                part.delete(); exp_q.delete();
                rd_idx = 0;
            end else begin
                if (out_ready && ev) begin
                    log_b.push_back(out_byte);
                    log_l.push_back(out_last);
                    log_c.push_back(cyc);
                    void'(exp_q.pop_front());
                    rd_idx = (rd_idx + 1) % 16;
                end
                if (in_valid && erdy) begin
                    part.push_back(in_byte);
                    if (part.size() == 16) begin
                        for (int k = 0; k < 16; k++) exp_q.push_back(part[src_idx(k, 1'b1)]);
                        part.delete();
                    end
                end
            end
            if (rt_valid && fwd_in_ready) rt_q.push_back(rt_byte);
            if (rt_out_valid && rt_ready) begin
                if (rt_q.size() == 0) chk("round_trip_extra", 1, 0);
                else begin
                    chk("round_trip", rt_out_byte, rt_q.pop_front());
                    rt_cmp++;
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        bit acc;
        int n = 0;
        in_valid = 1'b1;
        in_byte  = b;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 200) begin
                chk("send_timeout", 0, 1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int t = 0;
        while (log_b.size() < n && t < 400) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (log_b.size() < n) chk("wait_out_timeout", log_b.size(), n);
    endtask

    task automatic clear_log();
        log_b.delete(); log_l.delete(); log_c.delete();
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
            chk("model_inv_map", src_idx(k, 1'b1), inv_seq[k]);
            chk("model_fwd_map", src_idx(k, 1'b0), fwd_seq[k]);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_last", out_last, 0);
        chk("reset_out_byte", out_byte, 8'h00);
        @(posedge clk);
        #1 rst = 1'b1;

        // single block, latency and literal InvShiftRows order
        clear_log();
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) send(8'(i));
        @(negedge clk);
        chk("pre_latency_valid", out_valid, 0);
        @(posedge clk);
        #1;
        send(8'h0F);
        @(negedge clk);
        chk("latency_valid", out_valid, 1);
        @(posedge clk);
        #1;
        wait_out(16);
        for (int j = 0; j < 16 && j < log_b.size(); j++) begin
            chk("single_byte", log_b[j], inv_seq[j]);
            chk("single_last", log_l[j], j == 15);
        end

        // back-to-back: three blocks, no output bubble
        clear_log();
        for (int i = 0; i < 48; i++) send(8'(i * 7 + 3));
        wait_out(48);
        for (int j = 1; j < 48 && j < log_c.size(); j++)
            chk("b2b_gap", log_c[j] - log_c[j-1], 1);
        for (int j = 0; j < 48 && j < log_l.size(); j++)
            chk("b2b_last", log_l[j], (j % 16) == 15);

        // backpressure: both banks fill, then drain in order
        clear_log();
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++) send(8'(i));
        in_valid = 1'b1;
        in_byte  = 8'hAA;
        @(negedge clk);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_out_byte", out_byte, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_out(32);
        for (int j = 0; j < 32 && j < log_b.size(); j++)
            chk("bp_drain_byte", log_b[j], (j / 16) * 16 + inv_seq[j % 16]);

        // rst_synch drops a partial block
        clear_log();
        for (int i = 0; i < 7; i++) send(8'hE0 + 8'(i));
        rst_synch = 1'b1;
        @(posedge clk);
        #1 rst_synch = 1'b0;
        for (int i = 0; i < 16; i++) send(8'h10 + 8'(i));
        wait_out(16);
        repeat (5) @(posedge clk);
        #1;
        chk("rs_count", log_b.size(), 16);
        for (int j = 0; j < 16 && j < log_b.size(); j++)
            chk("rs_byte", log_b[j], 8'h10 + inv_seq[j]);

        // randomized traffic plus forward->inverse round trip
        repeat (600) begin
            in_valid  = ($urandom % 4) != 0;
            in_byte   = 8'($urandom);
            out_ready = ($urandom % 3) != 0;
            rst_synch = ($urandom % 200) == 0;
            rt_valid  = ($urandom % 3) != 0;
            rt_byte   = 8'($urandom);
            rt_ready  = ($urandom % 4) != 0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; rst_synch = 1'b0; rt_valid = 1'b0;
        out_ready = 1'b1; rt_ready = 1'b1;
        repeat (80) @(posedge clk);
        #1;
        chk("round_trip_seen", rt_cmp > 16, 1);

        // async reset mid-drain at rd_cnt=5
        clear_log();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(8'h40 + 8'(i));
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        chk("pre_rst_drained", log_b.size(), 5);
        #1 rst = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_out_byte", out_byte, 8'h00);
        chk("arst_out_last", out_last, 0);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        clear_log();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(8'h50 + 8'(i));
        wait_out(16);
        for (int j = 0; j < 16 && j < log_b.size(); j++)
            chk("post_arst_byte", log_b[j], 8'h50 + inv_seq[j]);

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
